hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller with a 3-entry EX/MEM/WB scoreboard.
//               Define HAZARD_FORWARD_EN to enable operand forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rR1,
   input  logic [4:0]  id_rR2,
   input  logic        id_re1,
   input  logic        id_re2,
   input  logic [4:0]  id_wR,
   input  logic        id_rf_we,
   input  logic [1:0]  id_rf_wsel,
   input  logic        ex_redirect,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [1:0]  fwd_A_sel,
   output logic [1:0]  fwd_B_sel,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef struct packed {
      logic       we;
      logic [4:0] wR;
      logic       is_load;
   } sb_entry_t;

   localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;
   localparam logic [1:0]  WSEL_LD  = 2'd1;
   localparam logic [1:0]  SEL_RF   = 2'd0;

   sb_entry_t   ex_q, ex_d;
   sb_entry_t   mem_q, mem_d;
   sb_entry_t   wb_q, wb_d;
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   logic        a_ex, a_mem, a_wb;
   logic        b_ex, b_mem, b_wb;
   logic        hazard;
   logic [1:0]  fwd_a, fwd_b;
   logic        unused_sb;

   function automatic logic src_match(input logic re, input logic [4:0] rR,
                                      input sb_entry_t e);
      return re && (rR != 5'd0) && e.we && (e.wR == rR);
   endfunction

   assign a_ex  = src_match(id_re1, id_rR1, ex_q);
   assign a_mem = src_match(id_re1, id_rR1, mem_q);
   assign a_wb  = src_match(id_re1, id_rR1, wb_q);
   assign b_ex  = src_match(id_re2, id_rR2, ex_q);
   assign b_mem = src_match(id_re2, id_rR2, mem_q);
   assign b_wb  = src_match(id_re2, id_rR2, wb_q);

`ifdef HAZARD_FORWARD_EN
   localparam logic [1:0] SEL_EX  = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;
   localparam logic [1:0] SEL_WB  = 2'd3;

   // Only a load in EX cannot be bypassed; its data arrives from MEM next cycle.
   assign hazard = ex_q.is_load && (a_ex || b_ex);

   always_comb begin
      fwd_a = SEL_RF;
      fwd_b = SEL_RF;
      if (a_ex)       fwd_a = SEL_EX;
      else if (a_mem) fwd_a = SEL_MEM;
      else if (a_wb)  fwd_a = SEL_WB;
      if (b_ex)       fwd_b = SEL_EX;
      else if (b_mem) fwd_b = SEL_MEM;
      else if (b_wb)  fwd_b = SEL_WB;
   end
`else
   // Register file is not write-through, so any in-flight writer blocks the read.
   assign hazard = a_ex || a_mem || a_wb || b_ex || b_mem || b_wb;
   assign fwd_a  = SEL_RF;
   assign fwd_b  = SEL_RF;
`endif

   assign unused_sb = ^{ex_q.is_load, mem_q.is_load, wb_q.is_load};

   always_comb begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      if (ex_redirect) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (hazard) begin
         stall_pc    = 1'b1;
         stall_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end
   end

   assign fwd_A_sel = fwd_a;
   assign fwd_B_sel = fwd_b;

   always_comb begin
      ex_d = '0;
      if (!flush_id_ex) begin
         ex_d.we      = id_rf_we;
         ex_d.wR      = id_wR;
         ex_d.is_load = (id_rf_wsel == WSEL_LD);
      end
      mem_d = ex_q;
      wb_d  = mem_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (stall_pc && (stall_cnt_q != CNT_MAX))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (ex_redirect && (flush_cnt_q != CNT_MAX))
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Directed testbench for hazard_ctrl; expectations follow the HAZARD_FORWARD_EN setting.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rR1, id_rR2, id_wR;
   logic        id_re1, id_re2, id_rf_we;
   logic [1:0]  id_rf_wsel;
   logic        ex_redirect;
   logic        stall_pc, stall_if_id, flush_if_id, flush_id_ex;
   logic [1:0]  fwd_A_sel, fwd_B_sel;
   logic [31:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_rR1      (id_rR1),
      .id_rR2      (id_rR2),
      .id_re1      (id_re1),
      .id_re2      (id_re2),
      .id_wR       (id_wR),
      .id_rf_we    (id_rf_we),
      .id_rf_wsel  (id_rf_wsel),
      .ex_redirect (ex_redirect),
      .stall_pc    (stall_pc),
      .stall_if_id (stall_if_id),
      .flush_if_id (flush_if_id),
      .flush_id_ex (flush_id_ex),
      .fwd_A_sel   (fwd_A_sel),
      .fwd_B_sel   (fwd_B_sel),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ctl(input string tag, input logic st, input logic fif, input logic fie);
      chk({tag, "_stall_pc"},    {31'd0, stall_pc},    {31'd0, st});
      chk({tag, "_stall_if_id"}, {31'd0, stall_if_id}, {31'd0, st});
      chk({tag, "_flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fif});
      chk({tag, "_flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fie});
   endtask

   task automatic set_id(input logic [4:0] r1, input logic e1, input logic [4:0] r2,
                         input logic e2, input logic [4:0] wr, input logic we,
                         input logic [1:0] wsel);
      id_rR1 = r1; id_re1 = e1; id_rR2 = r2; id_re2 = e2;
      id_wR = wr; id_rf_we = we; id_rf_wsel = wsel;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      repeat (3) cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      ex_redirect = 1'b0;
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      repeat (2) cyc();
      rst = 1'b0;
      #1;
      // Reset state
      ctl("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_fwdA", {30'd0, fwd_A_sel}, 32'd0);
      chk("rst_fwdB", {30'd0, fwd_B_sel}, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);
      ex_redirect = 1'b1;
      #1;
      ctl("rst_redir", 1'b0, 1'b1, 1'b1);
      ex_redirect = 1'b0;
      #1;

      // ALU writer x5 followed by reader of x5
      set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'd0);
      #1;
      ctl("t1_writer", 1'b0, 1'b0, 1'b0);
      cyc();
      set_id(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'd0);
      #1;
`ifdef HAZARD_FORWARD_EN
      ctl("t1_fwd", 1'b0, 1'b0, 1'b0);
      chk("t1_fwdA", {30'd0, fwd_A_sel}, 32'd1);
      chk("t1_fwdB", {30'd0, fwd_B_sel}, 32'd0);
      cyc();
      chk("t1_stall_cnt", stall_cnt, 32'd0);
`else
      ctl("t1_s1", 1'b1, 1'b0, 1'b1);
      chk("t1_fwdA", {30'd0, fwd_A_sel}, 32'd0);
      cyc();
      ctl("t1_s2", 1'b1, 1'b0, 1'b1);
      cyc();
      ctl("t1_s3", 1'b1, 1'b0, 1'b1);
      cyc();
      ctl("t1_release", 1'b0, 1'b0, 1'b0);
      chk("t1_stall_cnt", stall_cnt, 32'd3);
      cyc();
`endif
      drain();

      // Load x7 followed by a use of x7 on both operands
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd1);
      #1;
      ctl("t2_load", 1'b0, 1'b0, 1'b0);
      cyc();
      set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 2'd0);
      #1;
      ctl("t2_s1", 1'b1, 1'b0, 1'b1);
      cyc();
`ifdef HAZARD_FORWARD_EN
      ctl("t2_release", 1'b0, 1'b0, 1'b0);
      chk("t2_fwdA", {30'd0, fwd_A_sel}, 32'd2);
      chk("t2_fwdB", {30'd0, fwd_B_sel}, 32'd2);
      cyc();
      chk("t2_stall_cnt", stall_cnt, 32'd1);
`else
      ctl("t2_s2", 1'b1, 1'b0, 1'b1);
      cyc();
      ctl("t2_s3", 1'b1, 1'b0, 1'b1);
      cyc();
      ctl("t2_release", 1'b0, 1'b0, 1'b0);
      cyc();
      chk("t2_stall_cnt", stall_cnt, 32'd6);
`endif
      drain();

      // Redirect coinciding with a load-use hazard
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1);
      #1;
      cyc();
      set_id(5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 2'd0);
      ex_redirect = 1'b1;
      #1;
      ctl("t3_redir", 1'b0, 1'b1, 1'b1);
      cyc();
      ex_redirect = 1'b0;
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      #1;
      ctl("t3_after", 1'b0, 1'b0, 1'b0);
      chk("t3_flush_cnt", flush_cnt, 32'd1);
`ifdef HAZARD_FORWARD_EN
      chk("t3_stall_cnt", stall_cnt, 32'd1);
`else
      chk("t3_stall_cnt", stall_cnt, 32'd6);
`endif
      drain();

      // Writes to x0 never hazard; unread sources never hazard
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1);
      #1;
      cyc();
      set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 2'd0);
      #1;
      ctl("t4_x0", 1'b0, 1'b0, 1'b0);
      chk("t4_x0_fwdA", {30'd0, fwd_A_sel}, 32'd0);
      chk("t4_x0_fwdB", {30'd0, fwd_B_sel}, 32'd0);
      cyc();
      drain();
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd0);
      #1;
      cyc();
      set_id(5'd3, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 2'd0);
      #1;
      ctl("t4_re0", 1'b0, 1'b0, 1'b0);
      chk("t4_re0_fwdA", {30'd0, fwd_A_sel}, 32'd0);
      drain();

      // Reset asserted during the second stall cycle
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0);
      #1;
      cyc();
      set_id(5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 2'd0);
      #1;
      cyc();
`ifndef HAZARD_FORWARD_EN
      ctl("t5_s2", 1'b1, 1'b0, 1'b1);
`endif
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      ctl("t5_post_rst", 1'b0, 1'b0, 1'b0);
      chk("t5_stall_cnt", stall_cnt, 32'd0);
      chk("t5_flush_cnt", flush_cnt, 32'd0);
      drain();

      // Counters saturate instead of wrapping
      @(negedge clk);
      dut.stall_cnt_q = 32'hFFFF_FFFE;
      dut.flush_cnt_q = 32'hFFFF_FFFF;
      cyc();
      chk("t6_preload", stall_cnt, 32'hFFFF_FFFE);
`ifdef HAZARD_FORWARD_EN
      for (int k = 0; k < 2; k++) begin
         set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 2'd1);
         #1;
         cyc();
         set_id(5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd0);
         #1;
         ctl("t6_lu", 1'b1, 1'b0, 1'b1);
         cyc();
         set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
         cyc();
      end
`else
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 2'd0);
      #1;
      cyc();
      set_id(5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd0);
      #1;
      ctl("t6_s1", 1'b1, 1'b0, 1'b1);
      repeat (3) cyc();
      ctl("t6_release", 1'b0, 1'b0, 1'b0);
`endif
      chk("t6_stall_sat", stall_cnt, 32'hFFFF_FFFF);
      set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
      ex_redirect = 1'b1;
      #1;
      cyc();
      ex_redirect = 1'b0;
      #1;
      chk("t6_flush_sat", flush_cnt, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
